vga_score_ctrl: RTL and testbench

Score sequencer for the VGA snake display. Maintains the current score and the high score as packed BCD and runs the play / game-over / high-score display state machine. Presents frame-stable digit values and per-digit enables to the per-slot 7-segment digit renderers, one renderer instance per digit slot. Display outputs change only at frame boundaries, so a digit never tears mid-frame.

---
 rtl/vga_score_if.sv | 31 +++
 rtl/vga_score_ctrl.sv | 153 +++++++++++++++
 tb/tb_vga_score_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_score_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_score_if                                                     |
// | Purpose  : Event pulses in, score and frame-stable display words out.       |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface vga_score_if #(
    parameter int NDIGITS = 3
);
    logic                   frame_start;
    logic                   new_game;
    logic                   point;
    logic                   game_over;
    logic [4*NDIGITS-1:0]   score_bcd;
    logic [4*NDIGITS-1:0]   high_bcd;
    logic                   new_high;
    logic [4*NDIGITS-1:0]   disp_digits;
    logic [NDIGITS-1:0]     disp_en;
    logic [1:0]             state;

    modport master (
        output frame_start, new_game, point, game_over,
        input  score_bcd, high_bcd, new_high, disp_digits, disp_en, state
    );

    modport slave (
        input  frame_start, new_game, point, game_over,
        output score_bcd, high_bcd, new_high, disp_digits, disp_en, state
    );
endinterface
`default_nettype wire

// File: rtl/vga_score_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_score_ctrl                                                   |
// | Purpose  : BCD score/high-score keeper and play/over/high display sequencer.|
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module vga_score_ctrl #(
    parameter int NDIGITS      = 3,
    parameter int BLINK_FRAMES = 30,
    parameter int BLINK_HALVES = 6
) (
    input  wire logic   clk,
    input  wire logic   reset_n,
    vga_score_if.slave  bus
);
    localparam int c_BCD_W = 4 * NDIGITS;
    localparam int c_FW    = $clog2(BLINK_FRAMES + 1);
    localparam int c_HW    = $clog2(BLINK_HALVES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2,
        ST_HIGH = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_BCD_W-1:0]     r_score;
    logic [c_BCD_W-1:0]     r_high;
    logic [c_BCD_W-1:0]     r_disp_digits;
    logic [NDIGITS-1:0]     r_disp_en;
    logic                   r_new_high;
    logic                   r_phase;
    logic [c_FW-1:0]        r_frame_cnt;
    logic [c_HW-1:0]        r_half_cnt;

    logic [c_BCD_W-1:0]     w_score_inc;
    logic [c_BCD_W-1:0]     w_src;
    logic [NDIGITS-1:0]     w_blank_en;
    logic [NDIGITS:0]       w_carry;
    logic                   w_phase_on;
    logic                   w_frame_wrap;
    logic                   w_last_half;

    assign w_carry[0] = 1'b1;

    // Ripple-carry BCD increment plus leading-zero mask of the display source.
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
        logic [3:0] w_d;
        assign w_d = r_score[4*gi +: 4];
        assign w_score_inc[4*gi +: 4] = !w_carry[gi]   ? w_d :
                                        (w_d == 4'd9)  ? 4'd0 : w_d + 4'd1;
        assign w_carry[gi+1] = w_carry[gi] && (w_d == 4'd9);
        assign w_blank_en[gi] = (gi == 0) || (|w_src[c_BCD_W-1:4*gi]);
    end

    assign w_frame_wrap = (r_state == ST_OVER) && bus.frame_start &&
                          (r_frame_cnt == c_FW'(BLINK_FRAMES - 1));
    assign w_last_half  = (r_half_cnt == c_HW'(BLINK_HALVES - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_src       = r_high;
        w_phase_on  = 1'b1;
        case (r_state)
            ST_PLAY: begin
                w_src = r_score;
                if (bus.game_over) w_state_nxt = ST_OVER;
            end
            ST_OVER: begin
                w_src      = r_score;
                w_phase_on = r_phase;
                if (w_frame_wrap && w_last_half) w_state_nxt = ST_HIGH;
            end
            default: ;
        endcase
        if (bus.new_game) w_state_nxt = ST_PLAY;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_score       <= '0;
            r_high        <= '0;
            r_new_high    <= 1'b0;
            r_disp_digits <= '0;
            r_disp_en     <= '0;
            r_frame_cnt   <= '0;
            r_half_cnt    <= '0;
            r_phase       <= 1'b1;
        end else begin
            // Latch from pre-update values so a frame never shows a half-applied event.
            if (bus.frame_start) begin
                r_disp_digits <= w_src;
                r_disp_en     <= w_blank_en & {NDIGITS{w_phase_on}};
            end
            if (bus.new_game) begin
                r_score     <= '0;
                r_new_high  <= 1'b0;
                r_frame_cnt <= '0;
                r_half_cnt  <= '0;
                r_phase     <= 1'b1;
            end else begin
                case (r_state)
                    ST_PLAY: begin
                        if (bus.game_over) begin
                            if (r_score > r_high) begin
                                r_high     <= r_score;
                                r_new_high <= 1'b1;
                            end else begin
                                r_new_high <= 1'b0;
                            end
                            r_frame_cnt <= '0;
                            r_half_cnt  <= '0;
                            r_phase     <= 1'b1;
                        end else if (bus.point && !w_carry[NDIGITS]) begin
                            r_score <= w_score_inc;
                        end
                    end
                    ST_OVER: begin
                        if (bus.frame_start) begin
                            if (w_frame_wrap) begin
                                r_frame_cnt <= '0;
                                r_phase     <= ~r_phase;
                                r_half_cnt  <= r_half_cnt + 1'b1;
                            end else begin
                                r_frame_cnt <= r_frame_cnt + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.score_bcd   = r_score;
    assign bus.high_bcd    = r_high;
    assign bus.new_high    = r_new_high;
    assign bus.disp_digits = r_disp_digits;
    assign bus.disp_en     = r_disp_en;
    assign bus.state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_vga_score_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vga_score_ctrl                                                |
// | Purpose  : Self-checking bench for vga_score_ctrl with a display scoreboard.|
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_vga_score_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   m_score = 0;
    int   m_high = 0;
    logic m_nh = 1'b0;

    typedef struct {
        logic [11:0] d;
        logic [2:0]  e;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    always #5 clk = ~clk;

    vga_score_if #(.NDIGITS(3)) bus ();

    vga_score_ctrl #(
        .NDIGITS(3),
        .BLINK_FRAMES(2),
        .BLINK_HALVES(6)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    function automatic logic [11:0] bcd(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [2:0] lz_en(input int v);
        return (v >= 100) ? 3'b111 : (v >= 10) ? 3'b011 : 3'b001;
    endfunction

    task automatic drive(input logic fs, input logic ng, input logic pt, input logic go, input int n);
        @(negedge clk);
        bus.frame_start = fs;
        bus.new_game    = ng;
        bus.point       = pt;
        bus.game_over   = go;
        repeat (n) @(negedge clk);
        bus.frame_start = 1'b0;
        bus.new_game    = 1'b0;
        bus.point       = 1'b0;
        bus.game_over   = 1'b0;
    endtask

    task automatic expect_frame(input logic [11:0] d, input logic [2:0] en, input logic pt);
        exp_t x;
        x.d = d;
        x.e = en;
        exp_q.push_back(x);
        drive(1'b1, 1'b0, pt, 1'b0, 1);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL reset_state got %0h want 0", bus.state); end
        checks++; if (bus.score_bcd !== 12'h000) begin errors++; $display("FAIL reset_score got %h want 000", bus.score_bcd); end
        checks++; if (bus.high_bcd !== 12'h000) begin errors++; $display("FAIL reset_high got %h want 000", bus.high_bcd); end
        checks++; if (bus.new_high !== 1'b0) begin errors++; $display("FAIL reset_new_high got %b want 0", bus.new_high); end
        checks++; if (bus.disp_digits !== 12'h000) begin errors++; $display("FAIL reset_digits got %h want 000", bus.disp_digits); end
        checks++; if (bus.disp_en !== 3'b000) begin errors++; $display("FAIL reset_en got %b want 000", bus.disp_en); end
        reset_n = 1'b1;
        expect_frame(bcd(m_high), lz_en(m_high), 1'b0);
        e = exp_q.pop_front();
        checks++; if (bus.disp_digits !== e.d) begin errors++; $display("FAIL idle_digits got %h want %h", bus.disp_digits, e.d); end
        checks++; if (bus.disp_en !== e.e) begin errors++; $display("FAIL idle_en got %b want %b", bus.disp_en, e.e); end
        checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL idle_state got %0h want 0", bus.state); end
    endtask

    task automatic test_score;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1);
        m_score = 0;
        checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL play_state got %0h want 1", bus.state); end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 123);
        m_score = 123;
        checks++; if (bus.score_bcd !== bcd(m_score)) begin errors++; $display("FAIL score_123 got %h want %h", bus.score_bcd, bcd(m_score)); end
        expect_frame(bcd(m_score), lz_en(m_score), 1'b0);
        e = exp_q.pop_front();
        checks++; if (bus.disp_digits !== e.d) begin errors++; $display("FAIL disp_123 got %h want %h", bus.disp_digits, e.d); end
        checks++; if (bus.disp_en !== e.e) begin errors++; $display("FAIL en_123 got %b want %b", bus.disp_en, e.e); end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 9);
        m_score = 9;
        expect_frame(bcd(m_score), lz_en(m_score), 1'b0);
        e = exp_q.pop_front();
        checks++; if (bus.disp_digits !== e.d) begin errors++; $display("FAIL disp_009 got %h want %h", bus.disp_digits, e.d); end
        checks++; if (bus.disp_en !== e.e) begin errors++; $display("FAIL en_009 got %b want %b", bus.disp_en, e.e); end
        // A point on the frame_start cycle shows up only at the following frame.
        expect_frame(bcd(m_score), lz_en(m_score), 1'b1);
        m_score = 10;
        e = exp_q.pop_front();
        checks++; if (bus.disp_digits !== e.d) begin errors++; $display("FAIL disp_coincident got %h want %h", bus.disp_digits, e.d); end
        checks++; if (bus.score_bcd !== bcd(m_score)) begin errors++; $display("FAIL score_coincident got %h want %h", bus.score_bcd, bcd(m_score)); end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 5);
        m_score = 15;
        checks++; if (bus.disp_digits !== bcd(9)) begin errors++; $display("FAIL disp_hold got %h want %h", bus.disp_digits, bcd(9)); end
        expect_frame(bcd(m_score), lz_en(m_score), 1'b0);
        e = exp_q.pop_front();
        checks++; if (bus.disp_digits !== e.d) begin errors++; $display("FAIL disp_015 got %h want %h", bus.disp_digits, e.d); end
        checks++; if (bus.disp_en !== e.e) begin errors++; $display("FAIL en_015 got %b want %b", bus.disp_en, e.e); end
    endtask

    task automatic test_saturate;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1005);
        m_score = (1005 > 999) ? 999 : 1005;
        checks++; if (bus.score_bcd !== 12'h999) begin errors++; $display("FAIL score_sat got %h want 999", bus.score_bcd); end
        expect_frame(bcd(m_score), lz_en(m_score), 1'b0);
        e = exp_q.pop_front();
        checks++; if (bus.disp_digits !== e.d) begin errors++; $display("FAIL disp_999 got %h want %h", bus.disp_digits, e.d); end
        checks++; if (bus.disp_en !== e.e) begin errors++; $display("FAIL en_999 got %b want %b", bus.disp_en, e.e); end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 42);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1);
        m_score = 42;
        if (m_score > m_high) begin m_high = m_score; m_nh = 1'b1; end else m_nh = 1'b0;
        checks++; if (bus.score_bcd !== bcd(m_score)) begin errors++; $display("FAIL score_drop_pt got %h want %h", bus.score_bcd, bcd(m_score)); end
        checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL over_state got %0h want 2", bus.state); end
        checks++; if (bus.high_bcd !== bcd(m_high)) begin errors++; $display("FAIL high_42 got %h want %h", bus.high_bcd, bcd(m_high)); end
    endtask

    task automatic test_high;
        int games[3] = '{57, 30, 57};
        for (int g = 0; g < 3; g++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1);
            checks++; if (bus.new_high !== 1'b0) begin errors++; $display("FAIL nh_clear_%0d got %b want 0", g, bus.new_high); end
            drive(1'b0, 1'b0, 1'b1, 1'b0, games[g]);
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1);
            m_score = games[g];
            if (m_score > m_high) begin m_high = m_score; m_nh = 1'b1; end else m_nh = 1'b0;
            checks++; if (bus.high_bcd !== bcd(m_high)) begin errors++; $display("FAIL high_game%0d got %h want %h", g, bus.high_bcd, bcd(m_high)); end
            checks++; if (bus.new_high !== m_nh) begin errors++; $display("FAIL nh_game%0d got %b want %b", g, bus.new_high, m_nh); end
            checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL over_game%0d got %0h want 2", g, bus.state); end
        end
    endtask

    task automatic test_blink;
        logic [1:0] want_st;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 12);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1);
        m_score = 12;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3);
        checks++; if (bus.score_bcd !== bcd(m_score)) begin errors++; $display("FAIL over_point got %h want %h", bus.score_bcd, bcd(m_score)); end
        for (int k = 0; k < 12; k++) begin
            expect_frame(bcd(m_score), (((k / 2) % 2) == 0) ? 3'b011 : 3'b000, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 2);
            e = exp_q.pop_front();
            want_st = (k == 11) ? 2'd3 : 2'd2;
            checks++; if (bus.disp_digits !== e.d) begin errors++; $display("FAIL blink_digits_%0d got %h want %h", k, bus.disp_digits, e.d); end
            checks++; if (bus.disp_en !== e.e) begin errors++; $display("FAIL blink_en_%0d got %b want %b", k, bus.disp_en, e.e); end
            checks++; if (bus.state !== want_st) begin errors++; $display("FAIL blink_state_%0d got %0h want %0h", k, bus.state, want_st); end
        end
        expect_frame(bcd(m_high), lz_en(m_high), 1'b0);
        e = exp_q.pop_front();
        checks++; if (bus.disp_digits !== e.d) begin errors++; $display("FAIL high_digits got %h want %h", bus.disp_digits, e.d); end
        checks++; if (bus.disp_en !== e.e) begin errors++; $display("FAIL high_en got %b want %b", bus.disp_en, e.e); end
    endtask

    task automatic test_mid_blink;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 5);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1);
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1);
        checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL mid_state got %0h want 1", bus.state); end
        checks++; if (bus.score_bcd !== 12'h000) begin errors++; $display("FAIL mid_score got %h want 000", bus.score_bcd); end
        checks++; if (bus.new_high !== 1'b0) begin errors++; $display("FAIL mid_nh got %b want 0", bus.new_high); end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 7);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        m_high = 0;
        checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL rst_play_state got %0h want 0", bus.state); end
        checks++; if (bus.score_bcd !== 12'h000) begin errors++; $display("FAIL rst_play_score got %h want 000", bus.score_bcd); end
        checks++; if (bus.high_bcd !== bcd(m_high)) begin errors++; $display("FAIL rst_play_high got %h want %h", bus.high_bcd, bcd(m_high)); end
        checks++; if (bus.disp_digits !== 12'h000) begin errors++; $display("FAIL rst_play_digits got %h want 000", bus.disp_digits); end
        checks++; if (bus.disp_en !== 3'b000) begin errors++; $display("FAIL rst_play_en got %b want 000", bus.disp_en); end
        reset_n = 1'b1;
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.new_game    = 1'b0;
        bus.point       = 1'b0;
        bus.game_over   = 1'b0;
        test_reset();
        test_score();
        test_saturate();
        test_high();
        test_blink();
        test_mid_blink();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
